// File: rtl/handshaked_rr_arbiter_pkg.sv
// Shared types and helpers for the handshaked round-robin arbiter:
// grant-state enum, round-robin candidate search and source-index width.
package handshaked_arb_pkg;

  typedef enum logic {
    IDLE,
    LOCKED
  } arbState_t;

  localparam int MAX_INPUTS = 64;

  typedef struct packed {
    logic found;
    int   idx;
  } rrResult_t;

  function automatic int srcWidth(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  // First valid requester at or after prio, wrapping modulo n.
  function automatic rrResult_t rr_next(input int prio,
                                        input logic [MAX_INPUTS-1:0] vldVec,
                                        input int n);
    rrResult_t r;
    int i;
    r = '0;
    for (int k = MAX_INPUTS - 1; k >= 0; k--) begin
      if (k < n) begin
        i = prio + k;
        if (i >= n) i = i - n;
        if (vldVec[i]) begin
          r.found = 1'b1;
          r.idx   = i;
        end
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/handshaked_rr_arbiter_if.sv
// Bundle of the multi-requester input channel and the single output channel.
interface handshaked_rr_arbiter_if
  import handshaked_arb_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int INPUTS     = 4
);
  localparam int SRC_W = srcWidth(INPUTS);

  logic [INPUTS*DATA_WIDTH-1:0] dataIn_data;
  logic [INPUTS-1:0]            dataIn_vld;
  logic [INPUTS-1:0]            dataIn_rd;
  logic [DATA_WIDTH-1:0]        dataOut_data;
  logic                         dataOut_vld;
  logic                         dataOut_rd;
  logic [SRC_W-1:0]             dataOut_src;

  modport slave (
    input  dataIn_data, dataIn_vld, dataOut_rd,
    output dataIn_rd, dataOut_data, dataOut_vld, dataOut_src
  );

  modport master (
    output dataIn_data, dataIn_vld, dataOut_rd,
    input  dataIn_rd, dataOut_data, dataOut_vld, dataOut_src
  );
endinterface

// File: rtl/handshaked_rr_arbiter_reg.sv
// Two-entry handshaked register (skid buffer): full throughput, ready taken
// from local occupancy only, so no combinational rd path crosses it.
module handshaked_reg #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] inData,
  input  logic                  inVld,
  output logic                  inRd,
  output logic [DATA_WIDTH-1:0] outData,
  output logic                  outVld,
  input  logic                  outRd
);
  logic [DATA_WIDTH-1:0] mem [2];
  logic                  wrPtr;
  logic                  rdPtr;
  logic [1:0]            count;
  logic                  push;
  logic                  pop;

  assign inRd    = !rst && (count != 2'd2);
  assign outVld  = !rst && (count != 2'd0);
  assign outData = mem[rdPtr];
  assign push    = inVld && inRd;
  assign pop     = outVld && outRd;

  always_ff @(posedge clk) begin
    if (rst) begin
      count  <= 2'd0;
      wrPtr  <= 1'b0;
      rdPtr  <= 1'b0;
      mem[0] <= '0;
      mem[1] <= '0;
    end else begin
      if (push) begin
        mem[wrPtr] <= inData;
        wrPtr      <= ~wrPtr;
      end
      if (pop) rdPtr <= ~rdPtr;
      count <= count + 2'(push) - 2'(pop);
    end
  end
endmodule

// File: rtl/handshaked_rr_arbiter.sv
// Round-robin arbiter onto one handshaked channel; a stalled grant is locked until
// it transfers. Define HANDSHAKED_RR_ARBITER_OUT_REG_EN to add a registered output.
module handshaked_rr_arbiter
  import handshaked_arb_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int INPUTS     = 4
) (
  input logic clk,
  input logic rst,
  handshaked_rr_arbiter_if.slave bus
);
  localparam int SRC_W = srcWidth(INPUTS);

  arbState_t             state, stateNxt;
  logic [SRC_W-1:0]      prio, prioNxt;
  logic [SRC_W-1:0]      lockIdx, lockIdxNxt;
  rrResult_t             cand;
  logic [MAX_INPUTS-1:0] vldExt;
  logic [SRC_W-1:0]      sel;
  logic                  coreVld;
  logic                  coreRd;
  logic                  xfer;
  logic [DATA_WIDTH-1:0] coreData;
  logic [INPUTS-1:0]     inRd;

  function automatic logic [SRC_W-1:0] nextIdx(input logic [SRC_W-1:0] idx);
    return (idx == SRC_W'(INPUTS - 1)) ? '0 : idx + 1'b1;
  endfunction

  assign vldExt = MAX_INPUTS'(bus.dataIn_vld);

  always_comb begin
    cand     = rr_next(int'(prio), vldExt, INPUTS);
    sel      = (state == LOCKED) ? lockIdx : SRC_W'(cand.idx);
    coreVld  = !rst && ((state == LOCKED) ? bus.dataIn_vld[lockIdx] : cand.found);
    coreData = bus.dataIn_data[sel*DATA_WIDTH +: DATA_WIDTH];
    inRd     = '0;
    // The locked owner keeps its ready even if it drops vld.
    if (!rst && (state == LOCKED || cand.found)) inRd[sel] = coreRd;
    xfer     = coreVld && coreRd;
  end

  assign bus.dataIn_rd = inRd;

  always_comb begin
    stateNxt   = state;
    prioNxt    = prio;
    lockIdxNxt = lockIdx;
    case (state)
      IDLE: begin
        if (cand.found) begin
          if (xfer) begin
            prioNxt = nextIdx(sel);
          end else begin
            stateNxt   = LOCKED;
            lockIdxNxt = sel;
          end
        end
      end
      LOCKED: begin
        if (xfer) begin
          stateNxt = IDLE;
          prioNxt  = nextIdx(lockIdx);
        end
      end
      default: stateNxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      prio    <= '0;
      lockIdx <= '0;
    end else begin
      state   <= stateNxt;
      prio    <= prioNxt;
      lockIdx <= lockIdxNxt;
    end
  end

`ifdef HANDSHAKED_RR_ARBITER_OUT_REG_EN
  logic [SRC_W+DATA_WIDTH-1:0] regOut;

  handshaked_reg #(
    .DATA_WIDTH(DATA_WIDTH + SRC_W)
  ) uOutReg (
    .clk    (clk),
    .rst    (rst),
    .inData ({sel, coreData}),
    .inVld  (coreVld),
    .inRd   (coreRd),
    .outData(regOut),
    .outVld (bus.dataOut_vld),
    .outRd  (bus.dataOut_rd)
  );

  assign bus.dataOut_data = regOut[DATA_WIDTH-1:0];
  assign bus.dataOut_src  = regOut[SRC_W+DATA_WIDTH-1:DATA_WIDTH];
`else
  assign coreRd           = bus.dataOut_rd;
  assign bus.dataOut_vld  = coreVld;
  assign bus.dataOut_data = coreData;
  assign bus.dataOut_src  = rst ? '0 : sel;
`endif
endmodule

// File: tb/tb_handshaked_rr_arbiter.sv
// Self-checking bench for handshaked_rr_arbiter (INPUTS=4, DATA_WIDTH=8), covering
// both the direct build and the HANDSHAKED_RR_ARBITER_OUT_REG_EN build.
module tb_handshaked_rr_arbiter;
  localparam int DW = 8;
  localparam int N  = 4;
  localparam logic [31:0] D_RR = {8'h43, 8'h32, 8'h21, 8'h10};

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  handshaked_rr_arbiter_if #(.DATA_WIDTH(DW), .INPUTS(N)) bus ();

  handshaked_rr_arbiter #(.DATA_WIDTH(DW), .INPUTS(N)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );

  int tests = 0;
  int fails = 0;
  int mPrio = 0;
  int mLock = -1;
  logic [7:0] seq [4] = '{8'h10, 8'h21, 8'h32, 8'h43};

  // Reference: owner is the locked requester, else first valid from mPrio cyclically.
  function automatic void model_eval(input logic [3:0] v, output int sel, output bit ev);
    ev  = 1'b0;
    sel = 0;
    if (mLock >= 0) begin
      sel = mLock;
      ev  = v[mLock];
    end else begin
      for (int k = 0; k < N; k++) begin
        if (!ev && v[(mPrio + k) % N]) begin
          ev  = 1'b1;
          sel = (mPrio + k) % N;
        end
      end
    end
  endfunction

  function automatic logic [14:0] predict(input logic [3:0] v, input logic [31:0] d,
                                          input logic ordy);
    int sel;
    bit ev;
    logic [3:0] rdv;
    model_eval(v, sel, ev);
    rdv = ((ev || mLock >= 0) && ordy) ? 4'(1 << sel) : 4'b0;
    return {ev, rdv, ev ? 2'(sel) : 2'b0, ev ? d[sel*8 +: 8] : 8'h0};
  endfunction

  task automatic model_commit(input logic [3:0] v, input logic ordy);
    int sel;
    bit ev;
    model_eval(v, sel, ev);
    if (ev && ordy) begin
      mPrio = (sel + 1) % N;
      mLock = -1;
    end else if (ev) begin
      mLock = sel;
    end
  endtask

  function automatic logic [14:0] observe();
    return {bus.dataOut_vld, bus.dataIn_rd,
            bus.dataOut_vld ? bus.dataOut_src : 2'b0,
            bus.dataOut_vld ? bus.dataOut_data : 8'h0};
  endfunction

  task automatic step(input logic r, input logic [3:0] v, input logic [31:0] d,
                      input logic ordy, output logic [14:0] exp, output logic [14:0] act);
    @(negedge clk);
    rst            = r;
    bus.dataIn_vld  = v;
    bus.dataIn_data = d;
    bus.dataOut_rd  = ordy;
    #1;
    exp = r ? 15'b0 : predict(v, d, ordy);
    act = observe();
    if (r) begin
      mPrio = 0;
      mLock = -1;
    end else begin
      model_commit(v, ordy);
    end
  endtask

  task automatic do_reset();
    logic [14:0] e, a;
    step(1'b1, 4'h0, 32'h0, 1'b0, e, a);
    step(1'b1, 4'h0, 32'h0, 1'b0, e, a);
  endtask

  task automatic test_reset();
    logic [14:0] e, a;
    for (int c = 0; c < 3; c++) begin
      step(1'b1, 4'hF, D_RR, 1'b1, e, a);
      tests++;
      if ({bus.dataOut_vld, bus.dataIn_rd, bus.dataOut_src} !== 7'b0) begin
        fails++;
        $display("FAIL reset_outputs: got vld/rd/src %b expected 0000000",
                 {bus.dataOut_vld, bus.dataIn_rd, bus.dataOut_src});
      end
    end
`ifndef HANDSHAKED_RR_ARBITER_OUT_REG_EN
    step(1'b0, 4'hF, D_RR, 1'b1, e, a);
    tests++;
    if ({bus.dataOut_vld, bus.dataOut_src, bus.dataOut_data} !== {1'b1, 2'd0, 8'h10}) begin
      fails++;
      $display("FAIL first_grant: got vld/src/data %b/%0d/%h expected 1/0/10",
               bus.dataOut_vld, bus.dataOut_src, bus.dataOut_data);
    end
`else
    step(1'b0, 4'hF, D_RR, 1'b1, e, a);
    tests++;
    if (bus.dataOut_vld !== 1'b0) begin
      fails++;
      $display("FAIL reg_latency: got vld %b expected 0", bus.dataOut_vld);
    end
    step(1'b0, 4'hF, D_RR, 1'b1, e, a);
    tests++;
    if ({bus.dataOut_vld, bus.dataOut_src, bus.dataOut_data} !== {1'b1, 2'd0, 8'h10}) begin
      fails++;
      $display("FAIL first_grant: got vld/src/data %b/%0d/%h expected 1/0/10",
               bus.dataOut_vld, bus.dataOut_src, bus.dataOut_data);
    end
`endif
  endtask

`ifndef HANDSHAKED_RR_ARBITER_OUT_REG_EN
  task automatic test_round_robin();
    logic [14:0] e, a;
    do_reset();
    for (int k = 0; k < 8; k++) begin
      step(1'b0, 4'hF, D_RR, 1'b1, e, a);
      tests++;
      if ({bus.dataOut_vld, bus.dataOut_src, bus.dataOut_data} !== {1'b1, 2'(k % 4), seq[k % 4]}) begin
        fails++;
        $display("FAIL round_robin[%0d]: got src/data %0d/%h expected %0d/%h",
                 k, bus.dataOut_src, bus.dataOut_data, k % 4, seq[k % 4]);
      end
    end
  endtask

  task automatic test_lock();
    logic [14:0] e, a;
    logic [31:0] d;
    d = {8'h00, 8'hA5, 8'h00, 8'h5A};
    do_reset();
    for (int c = 0; c < 5; c++) begin
      step(1'b0, (c >= 2) ? 4'b0101 : 4'b0100, d, 1'b0, e, a);
      tests++;
      if ({bus.dataOut_vld, bus.dataIn_rd, bus.dataOut_src, bus.dataOut_data} !==
          {1'b1, 4'b0000, 2'd2, 8'hA5}) begin
        fails++;
        $display("FAIL lock_hold[%0d]: got vld/rd/src/data %b/%b/%0d/%h expected 1/0000/2/a5",
                 c, bus.dataOut_vld, bus.dataIn_rd, bus.dataOut_src, bus.dataOut_data);
      end
    end
    step(1'b0, 4'b0101, d, 1'b1, e, a);
    tests++;
    if ({bus.dataIn_rd, bus.dataOut_src, bus.dataOut_data} !== {4'b0100, 2'd2, 8'hA5}) begin
      fails++;
      $display("FAIL lock_release: got rd/src/data %b/%0d/%h expected 0100/2/a5",
               bus.dataIn_rd, bus.dataOut_src, bus.dataOut_data);
    end
    step(1'b0, 4'b0101, d, 1'b1, e, a);
    tests++;
    if ({bus.dataIn_rd, bus.dataOut_src, bus.dataOut_data} !== {4'b0001, 2'd0, 8'h5A}) begin
      fails++;
      $display("FAIL lock_next: got rd/src/data %b/%0d/%h expected 0001/0/5a",
               bus.dataIn_rd, bus.dataOut_src, bus.dataOut_data);
    end
  endtask

  task automatic test_wrap();
    logic [14:0] e, a;
    int expSrc [3] = '{3, 1, 2};
    logic [3:0] vv [3] = '{4'b1010, 4'b1010, 4'b1111};
    do_reset();
    step(1'b0, 4'b0100, D_RR, 1'b1, e, a);
    for (int k = 0; k < 3; k++) begin
      step(1'b0, vv[k], D_RR, 1'b1, e, a);
      tests++;
      if ({bus.dataOut_vld, bus.dataOut_src} !== {1'b1, 2'(expSrc[k])}) begin
        fails++;
        $display("FAIL wrap[%0d]: got vld/src %b/%0d expected 1/%0d",
                 k, bus.dataOut_vld, bus.dataOut_src, expSrc[k]);
      end
    end
  endtask

  task automatic test_reset_mid_lock();
    logic [14:0] e, a;
    do_reset();
    step(1'b0, 4'b0010, D_RR, 1'b0, e, a);
    step(1'b1, 4'b0010, D_RR, 1'b1, e, a);
    tests++;
    if ({bus.dataOut_vld, bus.dataIn_rd} !== 5'b0) begin
      fails++;
      $display("FAIL reset_mid_lock: got vld/rd %b/%b expected 0/0000",
               bus.dataOut_vld, bus.dataIn_rd);
    end
    step(1'b0, 4'hF, D_RR, 1'b1, e, a);
    tests++;
    if ({bus.dataOut_vld, bus.dataOut_src} !== {1'b1, 2'd0}) begin
      fails++;
      $display("FAIL after_reset_lock: got vld/src %b/%0d expected 1/0",
               bus.dataOut_vld, bus.dataOut_src);
    end
  endtask

  task automatic test_random();
    logic [14:0] e, a;
    do_reset();
    for (int c = 0; c < 400; c++) begin
      step(($urandom_range(0, 59) == 0), 4'($urandom), $urandom,
           ($urandom_range(0, 9) < 6), e, a);
      tests++;
      if (a !== e) begin
        fails++;
        $display("FAIL random[%0d]: got vld/rd/src/data %b expected %b", c, a, e);
      end
    end
  endtask
`else
  task automatic test_round_robin();
    logic [14:0] e, a;
    do_reset();
    step(1'b0, 4'hF, D_RR, 1'b1, e, a);
    for (int k = 0; k < 8; k++) begin
      step(1'b0, 4'hF, D_RR, 1'b1, e, a);
      tests++;
      if ({bus.dataOut_vld, bus.dataOut_src, bus.dataOut_data} !== {1'b1, 2'(k % 4), seq[k % 4]}) begin
        fails++;
        $display("FAIL reg_round_robin[%0d]: got vld/src/data %b/%0d/%h expected 1/%0d/%h",
                 k, bus.dataOut_vld, bus.dataOut_src, bus.dataOut_data, k % 4, seq[k % 4]);
      end
    end
  endtask

  task automatic test_toggle();
    logic [14:0] e, a;
    int idx = 0;
    do_reset();
    for (int c = 0; c < 40; c++) begin
      step(1'b0, 4'hF, D_RR, (c % 2 == 0), e, a);
      tests++;
      if ($countones(bus.dataIn_rd) > 1) begin
        fails++;
        $display("FAIL rd_onehot[%0d]: got rd %b expected at most one bit", c, bus.dataIn_rd);
      end
      if (bus.dataOut_vld && bus.dataOut_rd) begin
        tests++;
        if ({bus.dataOut_src, bus.dataOut_data} !== {2'(idx % 4), seq[idx % 4]}) begin
          fails++;
          $display("FAIL toggle_order[%0d]: got src/data %0d/%h expected %0d/%h",
                   idx, bus.dataOut_src, bus.dataOut_data, idx % 4, seq[idx % 4]);
        end
        idx++;
      end
    end
    tests++;
    if (idx < 15) begin
      fails++;
      $display("FAIL toggle_count: got %0d words expected at least 15", idx);
    end
  endtask
`endif

  initial begin
    rst             = 1'b1;
    bus.dataIn_vld  = '0;
    bus.dataIn_data = '0;
    bus.dataOut_rd  = 1'b0;
    test_reset();
    test_round_robin();
`ifndef HANDSHAKED_RR_ARBITER_OUT_REG_EN
    test_lock();
    test_wrap();
    test_reset_mid_lock();
    test_random();
`else
    test_toggle();
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/handshaked_rr_arbiter.md
# handshaked_rr_arbiter

Round-robin arbiter that shares one handshaked (data/vld/rd) channel between `INPUTS` requesters. It sits upstream of a plain handshaked wire or register stage and multiplexes producers onto it. Each granted word is held stable until the consumer accepts it, so the output obeys the vld-hold rule. An optional registered output stage breaks the combinational rd path.

## Interface
Parameters:
- `DATA_WIDTH`, 8: width of one data word.
- `INPUTS`, 4: number of requesters. Must be ≥ 2.

Ports:
- `clk`  in  1  sole clock; all state updates on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `dataIn_data`  in  `INPUTS*DATA_WIDTH`  packed input words; requester i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
- `dataIn_vld`  in  `INPUTS`  per-requester valid.
- `dataIn_rd`  out  `INPUTS`  per-requester ready. At most one bit is set.
- `dataOut_data`  out  `DATA_WIDTH`  granted word.
- `dataOut_vld`  out  1  output valid.
- `dataOut_rd`  in  1  consumer ready.
- `dataOut_src`  out  `$clog2(INPUTS)`  index of the requester that owns `dataOut_data`.

## Operation
- Transfer on any channel = vld & rd high in the same cycle.
- State: `prio` (index, reset 0), `state` ∈ {IDLE, LOCKED}, `lock_idx` (reset 0).
- **IDLE:**
  - Candidate = first i with `dataIn_vld[i]`, scanning `prio`, `prio+1`, … cyclically mod `INPUTS`.
  - If no candidate: `dataOut_vld`=0 and all `dataIn_rd`=0.
  - Otherwise output shows the candidate: data, vld=1, src=candidate.
  - Candidate also gets `dataIn_rd[cand] = dataOut_rd`.
  - If accepted: `prio ← cand+1` (wraps at `INPUTS-1`→0) and state stays IDLE.
  - If not accepted: `lock_idx ← cand` and state goes to LOCKED.
- **LOCKED:**
  - Mux is fixed to `lock_idx`, whatever other inputs are valid.
  - `dataOut_vld = dataIn_vld[lock_idx]` and `dataIn_rd[lock_idx] = dataOut_rd`.
  - On transfer: `prio ← lock_idx+1` and state returns to IDLE.
  - If the locked requester drops vld (protocol violation), the lock is still held. No other requester is granted until a transfer occurs.
- Fairness: a requester that stays valid is served within `INPUTS` transfers.
- During `rst`: all `dataIn_rd`=0 and `dataOut_vld`=0. State is forced to IDLE, `prio`=0, `lock_idx`=0.
- Reset mid-LOCKED discards the lock with no transfer. The first grant after reset follows `prio`=0.

## Timing
- Without output register:
  - Latency is 0 cycles; data/vld/src are combinational from inputs and state.
  - `dataIn_rd` is combinational from `dataOut_rd`.
  - Throughput is 1 word/cycle.
- Grant order updates on the clock edge after each transfer. Back-to-back transfers from different requesters in consecutive cycles are allowed.
- Reset values: `dataOut_vld`=0, `dataIn_rd`=0, `dataOut_src`=0. `dataOut_data` is don't-care while vld=0.

## Configuration
- Macro `HANDSHAKED_RR_ARBITER_OUT_REG_EN`.
- **Defined:** a 2-entry handshaked register (skid buffer) is placed between the arbiter core and `dataOut_*`.
  - `dataOut_src` is carried through the register alongside the data.
  - Latency is 1 cycle and throughput is 1 word/cycle.
  - `dataIn_rd` no longer depends combinationally on `dataOut_rd`.
  - Core rd = register not full.
  - All register outputs reset to 0, entries empty.
- **Undefined:** the direct combinational path described above.

## Structure
- Package `handshaked_arb_pkg`:
  - state enum type (IDLE, LOCKED);
  - function `rr_next(prio, vld_vec)` returning the candidate index and a found flag;
  - localparam helper for src width.
- Sub-module `handshaked_reg`: parameters `DATA_WIDTH`, same `clk`/`rst`. Instantiated only under the macro, with width `DATA_WIDTH + $clog2(INPUTS)`.

## Test plan
All scenarios use `INPUTS`=4 and `DATA_WIDTH`=8.
- **Reset:** `rst`=1 for 3 cycles with all `dataIn_vld`=1 and `dataOut_rd`=1 → `dataOut_vld`=0 and `dataIn_rd`=0000 throughout. First grant after release is src 0.
- **Round robin:** all four inputs valid with data 0x10,0x21,0x32,0x43; `dataOut_rd`=1 → outputs 0x10,0x21,0x32,0x43,0x10… on consecutive cycles, src 0,1,2,3,0.
- **Lock under backpressure:**
  - In IDLE with `prio`=0, input 2 alone valid (0xA5) and `dataOut_rd`=0 for 5 cycles → output stays 0xA5, src=2.
  - Input 0 raised in cycle 2 is not granted.
  - After rd=1, next word is from input 0.
- **Wrap-around:** `prio`=3 with inputs 1 and 3 valid → input 3 is served first, then input 1, then `prio`=2.
- **Reset mid-lock:** LOCKED on input 1, then `rst` pulse for 1 cycle → no transfer from input 1 in that cycle. Afterwards arbitration restarts at `prio`=0.
- **Output register (macro defined):** the round-robin sequence appears one cycle later. With `dataOut_rd` toggling 1,0,1,0 → no word is lost or duplicated and order is preserved.
